// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the mem_arbiter block: FSM state encoding,
// bus field widths and the requester-count ceiling.
package mem_arbiter_pkg;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int STRB_W      = 4;
    localparam int MAX_MASTERS = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester-side (m_*) and slave-side (s_*) signals around
// mem_arbiter. Modports: master (requesters), slave (memory), arbiter (DUT).
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2
);

    logic [NUM_MASTERS-1:0]        m_valid;
    logic [ADDR_W*NUM_MASTERS-1:0] m_addr;
    logic [DATA_W*NUM_MASTERS-1:0] m_wdata;
    logic [STRB_W*NUM_MASTERS-1:0] m_wstrb;
    logic [NUM_MASTERS-1:0]        m_ready;
    logic                          m_error;
    logic [DATA_W-1:0]             m_rdata;

    logic                          s_valid;
    logic [ADDR_W-1:0]             s_addr;
    logic [DATA_W-1:0]             s_wdata;
    logic [STRB_W-1:0]             s_wstrb;
    logic                          s_ready;
    logic                          s_error;
    logic [DATA_W-1:0]             s_rdata;

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_error, m_rdata
    );

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_error, s_rdata
    );

    modport arbiter (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_error, s_rdata,
        output m_ready, m_error, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester after
// last_grant in ascending index order, wrapping at NUM_MASTERS.
module mem_arbiter_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       winner,
    output logic                   found
);

    logic [IDX_W:0] cand;

    // Scan farthest-to-nearest so the nearest requester after last_grant wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_MASTERS)) begin
                cand = cand - (IDX_W + 1)'(NUM_MASTERS);
            end
            if (req[cand[IDX_W-1:0]]) begin
                winner = cand[IDX_W-1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one slave port between NUM_MASTERS requesters,
// one outstanding transaction at a time (IDLE -> BUSY -> DONE).
// Optional feature: define MEM_ARBITER_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES cycles without s_ready (m_error=1, m_rdata=0).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            clk,
    input logic            rst_n,
    mem_arbiter_if.arbiter bus
);

    localparam int IDX_W = idx_width(NUM_MASTERS);

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       grant_reg, grant_next;
    logic [IDX_W-1:0]       last_grant_reg, last_grant_next;
    logic                   s_valid_reg, s_valid_next;
    logic [ADDR_W-1:0]      s_addr_reg, s_addr_next;
    logic [DATA_W-1:0]      s_wdata_reg, s_wdata_next;
    logic [STRB_W-1:0]      s_wstrb_reg, s_wstrb_next;
    logic [NUM_MASTERS-1:0] m_ready_reg, m_ready_next;
    logic                   m_error_reg, m_error_next;
    logic [DATA_W-1:0]      m_rdata_reg, m_rdata_next;

    logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
    logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];
    logic [STRB_W-1:0]      wstrb_arr [NUM_MASTERS];
    logic [IDX_W-1:0]       pick;
    logic                   pick_found;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic [15:0]            count_reg, count_next;
`endif

    // Split the flat request buses into per-master fields.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_split
        assign addr_arr[gi]  = bus.m_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = bus.m_wdata[gi*DATA_W +: DATA_W];
        assign wstrb_arr[gi] = bus.m_wstrb[gi*STRB_W +: STRB_W];
    end

    mem_arbiter_rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IDX_W      (IDX_W)
    ) u_pick (
        .req       (bus.m_valid),
        .last_grant(last_grant_reg),
        .winner    (pick),
        .found     (pick_found)
    );

    // State and output registers; reset puts every output at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= IDX_W'(NUM_MASTERS - 1);
            s_valid_reg    <= 1'b0;
            s_addr_reg     <= '0;
            s_wdata_reg    <= '0;
            s_wstrb_reg    <= '0;
            m_ready_reg    <= '0;
            m_error_reg    <= 1'b0;
            m_rdata_reg    <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            count_reg      <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            s_valid_reg    <= s_valid_next;
            s_addr_reg     <= s_addr_next;
            s_wdata_reg    <= s_wdata_next;
            s_wstrb_reg    <= s_wstrb_next;
            m_ready_reg    <= m_ready_next;
            m_error_reg    <= m_error_next;
            m_rdata_reg    <= m_rdata_next;
`ifdef MEM_ARBITER_TIMEOUT_EN
            count_reg      <= count_next;
`endif
        end
    end

    // Next-state logic: grant in IDLE, wait for the slave in BUSY, one
    // settling cycle in DONE. Completion outputs default to zero so they
    // form single-cycle pulses.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        s_valid_next    = s_valid_reg;
        s_addr_next     = s_addr_reg;
        s_wdata_next    = s_wdata_reg;
        s_wstrb_next    = s_wstrb_reg;
        m_ready_next    = '0;
        m_error_next    = 1'b0;
        m_rdata_next    = '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        count_next      = count_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    s_valid_next    = 1'b1;
                    s_addr_next     = addr_arr[pick];
                    s_wdata_next    = wdata_arr[pick];
                    s_wstrb_next    = wstrb_arr[pick];
                    grant_next      = pick;
                    last_grant_next = pick;
                    state_next      = ST_BUSY;
`ifdef MEM_ARBITER_TIMEOUT_EN
                    count_next      = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (bus.s_ready) begin
                    s_valid_next            = 1'b0;
                    m_ready_next[grant_reg] = 1'b1;
                    m_rdata_next            = bus.s_rdata;
                    m_error_next            = bus.s_error;
                    state_next              = ST_DONE;
                end
`ifdef MEM_ARBITER_TIMEOUT_EN
                else if (count_reg == 16'(TIMEOUT_CYCLES - 1)) begin
                    // Slave never answered: complete the master with an error.
                    s_valid_next            = 1'b0;
                    m_ready_next[grant_reg] = 1'b1;
                    m_error_next            = 1'b1;
                    state_next              = ST_DONE;
                end else begin
                    count_next = count_reg + 16'd1;
                end
`endif
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.s_valid = s_valid_reg;
    assign bus.s_addr  = s_addr_reg;
    assign bus.s_wdata = s_wdata_reg;
    assign bus.s_wstrb = s_wstrb_reg;
    assign bus.m_ready = m_ready_reg;
    assign bus.m_error = m_error_reg;
    assign bus.m_rdata = m_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: random master requests, a memory slave
// with random latency, errors and stray s_ready pulses, and a transaction-level
// timing model (grant / response / completion cycle numbers). Covers reset
// values, rotation, latency, error pulses, async reset mid-BUSY and, with
// MEM_ARBITER_TIMEOUT_EN, the timeout path.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_MASTERS(N)) bus ();

    mem_arbiter #(
        .NUM_MASTERS   (N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Master-side state: pending request and its contents.
    bit          pend      [N];
    logic [31:0] req_addr  [N];
    logic [31:0] req_wdata [N];
    logic [3:0]  req_wstrb [N];
    logic [31:0] mem       [16];

    // Outstanding-transaction timeline in cycle numbers.
    bit          out_act;
    bit          to_flag;
    int          win, sv_from, end_c, late_c, free_c, last_g;
    logic [31:0] exp_rdata;
    logic        exp_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_s_valid"}, 32'(bus.s_valid), 32'd0);
        check_eq({pfx, "_s_addr"},  bus.s_addr,       32'd0);
        check_eq({pfx, "_s_wdata"}, bus.s_wdata,      32'd0);
        check_eq({pfx, "_s_wstrb"}, 32'(bus.s_wstrb), 32'd0);
        check_eq({pfx, "_m_ready"}, 32'(bus.m_ready), 32'd0);
        check_eq({pfx, "_m_error"}, 32'(bus.m_error), 32'd0);
        check_eq({pfx, "_m_rdata"}, bus.m_rdata,      32'd0);
    endtask

    task automatic new_req(input int i);
        req_addr[i]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        req_wdata[i] = $urandom;
        req_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
        pend[i]      = 1'b1;
    endtask

    task automatic drive_masters();
        logic [N-1:0]    v;
        logic [32*N-1:0] a;
        logic [32*N-1:0] d;
        logic [4*N-1:0]  s;
        v = '0; a = '0; d = '0; s = '0;
        for (int i = 0; i < N; i++) begin
            v[i]          = pend[i];
            a[32*i +: 32] = req_addr[i];
            d[32*i +: 32] = req_wdata[i];
            s[4*i +: 4]   = req_wstrb[i];
        end
        bus.m_valid = v;
        bus.m_addr  = a;
        bus.m_wdata = d;
        bus.m_wstrb = s;
    endtask

    // Expected outputs for the current cycle, from the transaction timeline.
    task automatic check_outputs();
        bit          e_sv;
        bit          done;
        logic [N-1:0] e_mr;
        e_sv = out_act && cyc >= sv_from && cyc <= end_c;
        done = out_act && cyc == end_c + 1;
        e_mr = '0;
        if (done) e_mr[win] = 1'b1;
        check_eq("s_valid", 32'(bus.s_valid), 32'(e_sv));
        check_eq("m_ready", 32'(bus.m_ready), 32'(e_mr));
        check_eq("m_rdata", bus.m_rdata, done ? exp_rdata : 32'd0);
        check_eq("m_error", 32'(bus.m_error), done ? 32'(exp_err) : 32'd0);
        if (e_sv) begin
            check_eq("s_addr",  bus.s_addr,       req_addr[win]);
            check_eq("s_wdata", bus.s_wdata,      req_wdata[win]);
            check_eq("s_wstrb", 32'(bus.s_wstrb), 32'(req_wstrb[win]));
        end
        if (done) begin
            $display("[TB] cyc %0d txn master %0d addr %h wstrb %b wdata %h rdata %h err %0d",
                     cyc, win, req_addr[win], req_wstrb[win], req_wdata[win], exp_rdata, exp_err);
            pend[win] = 1'b0;
            out_act   = 1'b0;
            free_c    = cyc + 1;
        end
    endtask

    task automatic update_masters();
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) != 0) new_req(i);
        end
    endtask

    // Round-robin rule: first pending master after the previous winner.
    task automatic arbitrate();
        int lat;
        if (!out_act && cyc >= free_c) begin
            for (int k = 1; k <= N; k++) begin
                if (!out_act && pend[(last_g + k) % N]) begin
                    win     = (last_g + k) % N;
                    out_act = 1'b1;
                end
            end
            if (out_act) begin
                last_g  = win;
                sv_from = cyc + 1;
                lat     = $urandom_range(0, 4);
`ifdef MEM_ARBITER_TIMEOUT_EN
                if ($urandom_range(0, 5) == 0) lat = TO + 2;
`endif
                to_flag = (lat >= TO);
                end_c   = to_flag ? sv_from + TO - 1 : sv_from + lat;
                late_c  = to_flag ? end_c + 1 : -1;
                if (to_flag) begin
                    exp_rdata = 32'd0;
                    exp_err   = 1'b1;
                end
            end
        end
    endtask

    // Memory slave: answers at end_c, otherwise stray pulses outside BUSY.
    task automatic slave_drive();
        logic [31:0] w;
        bus.s_ready = 1'b0;
        bus.s_error = 1'b0;
        bus.s_rdata = '0;
        if (out_act && cyc == end_c && !to_flag) begin
            w           = mem[req_addr[win][5:2]];
            bus.s_ready = 1'b1;
            bus.s_rdata = w;
            bus.s_error = ($urandom_range(0, 7) == 0);
            exp_rdata   = w;
            exp_err     = bus.s_error;
            for (int b = 0; b < 4; b++) begin
                if (req_wstrb[win][b]) w[8*b +: 8] = req_wdata[win][8*b +: 8];
            end
            mem[req_addr[win][5:2]] = w;
        end else if (cyc == late_c ||
                     (!(out_act && cyc >= sv_from && cyc <= end_c) && $urandom_range(0, 5) == 0)) begin
            bus.s_ready = 1'b1;
            bus.s_rdata = $urandom;
            bus.s_error = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
        update_masters();
        drive_masters();
        arbitrate();
        slave_drive();
    endtask

    task automatic model_reset();
        out_act = 1'b0;
        to_flag = 1'b0;
        last_g  = N - 1;
        free_c  = 0;
        late_c  = -1;
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
        end
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        model_reset();
        drive_masters();
        bus.s_ready = 1'b0; bus.s_error = 1'b0; bus.s_rdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        repeat (1500) step();

        // Asynchronous reset while a transaction is in BUSY.
        guard = 0;
        while (!(out_act && cyc >= sv_from && cyc <= end_c) && guard < 200) begin
            step();
            guard++;
        end
        check_eq("busy_reached", 32'(guard < 200), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        for (int i = 0; i < N; i++) begin
            new_req(i);
            req_addr[i] = 32'h40 + 32'(i * 4);
        end
        drive_masters();
        bus.s_ready = 1'b0; bus.s_error = 1'b0; bus.s_rdata = '0;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        check_all_zero("in_rst");
        @(negedge clk);
        rst_n = 1'b1;
        arbitrate();
        slave_drive();
        check_eq("post_rst_winner", 32'(win), 32'd0);

        repeat (300) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares one `mem_*` slave port, such as a RAM or peripheral block, between `NUM_MASTERS` requesters (CPU instruction, CPU data, DMA). Transactions are non-overlapping: exactly one is outstanding at a time, and it is forwarded unchanged to the slave. Sits between the bus masters and the memory/peripheral decode.

## Interface
- `NUM_MASTERS`, 2: requester count, 2..8.
- `TIMEOUT_CYCLES`, 255: slave response limit in cycles, used only with the timeout feature.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m_valid` in N: per-master request.
- `m_addr` in 32·N: byte address, master i at bits [32i+31:32i].
- `m_wdata` in 32·N: write data.
- `m_wstrb` in 4·N: byte write enables; all zero means read.
- `m_ready` out N: one-cycle completion pulse to the granted master.
- `m_error` out 1: error qualifier, valid when any `m_ready` bit is set.
- `m_rdata` out 32: read data, valid when any `m_ready` bit is set.
- `s_valid` out 1: request to slave.
- `s_addr` out 32: address to slave.
- `s_wdata` out 32: write data to slave.
- `s_wstrb` out 4: byte write enables to slave.
- `s_ready` in 1: one-cycle slave completion pulse.
- `s_error` in 1: slave error, sampled with `s_ready`.
- `s_rdata` in 32: slave read data, sampled with `s_ready`.

## Operation
- All outputs are registered.
- Reset values: `s_valid=0`, `s_addr=0`, `s_wdata=0`, `s_wstrb=0`, `m_ready=0`, `m_error=0`, `m_rdata=0`, state=IDLE, `last_grant=NUM_MASTERS-1`.
- Masters hold `m_valid`, `m_addr`, `m_wdata` and `m_wstrb` stable until they see `m_ready`. They drop `m_valid` the cycle after `m_ready` unless they are issuing a new request.
- State IDLE:
  - If any `m_valid` is set, select the first requester after `last_grant` in ascending index order, wrapping at N.
  - Latch that master's addr, wdata and wstrb into `s_*`, set `s_valid=1`, record `grant` and `last_grant`, and go to BUSY.
- State BUSY:
  - `s_*` held constant.
  - On `s_ready=1`: clear `s_valid`, pulse `m_ready[grant]` for one cycle with `m_rdata=s_rdata` and `m_error=s_error`, then go to DONE.
- State DONE:
  - One idle cycle that lets the completed master deassert `m_valid`. No new grant in this cycle.
  - Always go to IDLE next.
- `m_rdata` and `m_error` return to 0 on the cycle after the pulse.
- Writes pass through unchanged: `m_rdata` echoes whatever the slave returns.
- `s_ready` is ignored outside BUSY, including late responses after a timeout.
- A master that drops `m_valid` while granted is a protocol violation. The transaction still completes and the `m_ready` pulse is still issued.
- Asynchronous reset mid-transaction returns every output to its reset value immediately. A slave response in flight is lost.

## Timing
- Request at cycle 0 gives `s_valid` at cycle 1.
- A slave responding at cycle k≥1 gives `m_ready` at cycle k+1.
- Single-cycle memory: request-to-`m_ready` latency is 3 cycles.
- Back-to-back requests from the same master: one grant per 4 cycles (IDLE, BUSY, BUSY-ready, DONE).
- All masters requesting continuously: strict rotation 0,1,…,N-1,0.
- Simultaneous new request and completion: the new request is evaluated in IDLE, after DONE.

## Configuration
- `MEM_ARBITER_TIMEOUT_EN` defined:
  - An 8..16-bit counter runs in BUSY and clears on entry.
  - If the counter reaches `TIMEOUT_CYCLES` without `s_ready`: drop `s_valid`, pulse `m_ready[grant]` with `m_error=1` and `m_rdata=0`, then go to DONE.
- Undefined: no counter is present, and BUSY waits indefinitely.

## Structure
- Package `mem_arbiter_pkg`:
  - State encoding: IDLE=0, BUSY=1, DONE=2.
  - `ADDR_W=32`, `DATA_W=32`, `STRB_W=4`.
  - Max `NUM_MASTERS` constant.
- Sub-module `mem_arbiter_rr_pick`: combinational round-robin picker. Inputs are the request vector and `last_grant`. Outputs are the winner index and a `found` flag.

## Test plan
- **Single read:** N=2, master 0 reads 0x10 with slave rdata 0xDEADBEEF → `s_valid` at cycle 1, `m_ready[0]` at cycle 3 with `m_rdata=0xDEADBEEF` and `m_error=0`.
- **Fairness:** both masters request continuously from reset → grants 0,1,0,1; each `m_ready` lands only on the granted bit, 4 cycles apart.
- **Byte write:** master 1 writes 0x000000AB with `wstrb=4'b0001` to 0x20 → `s_wstrb=0001`, `s_addr=0x20`, `m_ready[1]` pulse; a later read returns byte 0 = 0xAB.
- **Slave error:** slave returns `s_error=1` → `m_error=1` for exactly the pulse cycle, 0 afterwards.
- **Timeout:** `MEM_ARBITER_TIMEOUT_EN` defined, `TIMEOUT_CYCLES=8`, slave never ready → `s_valid` drops and `m_ready` is pulsed with `m_error=1` and `m_rdata=0` eight cycles after grant; a late `s_ready` is ignored.
- **Reset mid-operation:** `rst_n` low during BUSY → all outputs 0 asynchronously; after release, a pending master 0 request is granted first.
